// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative wide multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/mult_limb_lane.sv
// One DSP column: WIDTH_A x LIMB_W product placed at a run-time bit offset.
module mult_limb_lane #(
  parameter int WIDTH_A = 256,
  parameter int LIMB_W  = 16,
  parameter int WIDTH_P = 304
) (
  input  logic [WIDTH_A-1:0] a,
  input  logic [LIMB_W-1:0]  limb,
  input  logic [31:0]        shift,
  output logic [WIDTH_P-1:0] pp
);

  localparam int PROD_W = WIDTH_A + LIMB_W;
  localparam int EXT_W  = PROD_W + WIDTH_P;

  logic [PROD_W-1:0] prod_s;
  logic [EXT_W-1:0]  ext_s;

  assign prod_s = PROD_W'(a) * PROD_W'(limb);
  // Shift in a wide frame, then keep the product-sized window; the dropped bits are always zero.
  assign ext_s  = EXT_W'(prod_s) << shift;
  assign pp     = ext_s[WIDTH_P-1:0];

endmodule

// File: rtl/mult_wide_iter.sv
// Iterative unsigned WIDTH_A x WIDTH_B multiplier: LANES limbs of b per cycle,
// accumulated over ITER cycles, with a valid/ready handshake on both sides.
module mult_wide_iter
  import mult_pkg::*;
#(
  parameter int WIDTH_A = 256,
  parameter int WIDTH_B = 48,
  parameter int LIMB_W  = 16,
  parameter int LANES   = 1,
  localparam int NUM_LIMBS = ceil_div(WIDTH_B, LIMB_W),
  localparam int ITER      = ceil_div(NUM_LIMBS, LANES),
  localparam int WIDTH_P   = WIDTH_A + WIDTH_B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] p,
  output logic               busy
);

  localparam int B_PAD = NUM_LIMBS * LIMB_W;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int OPT_N = 2 ** CNT_W;

  state_e             state_r;
  logic [WIDTH_A-1:0] a_r;
  logic [B_PAD-1:0]   b_r;
  logic [WIDTH_P-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH_P-1:0] pp_s    [LANES];
  logic [WIDTH_P-1:0] chain_s [LANES+1];
  logic               accept_s;

  assign in_ready = rst_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  assign chain_s[0] = acc_r;

  // Per lane, a table of limb and offset indexed by the counter; slots past the top limb read zero.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LIMB_W-1:0] opt_limb_s  [OPT_N];
    logic [31:0]       opt_shift_s [OPT_N];

    for (genvar i = 0; i < OPT_N; i++) begin : g_opt
      if ((i < ITER) && ((i * LANES + l) < NUM_LIMBS)) begin : g_live
        assign opt_limb_s[i]  = b_r[(i * LANES + l) * LIMB_W +: LIMB_W];
        assign opt_shift_s[i] = 32'((i * LANES + l) * LIMB_W);
      end else begin : g_pad
        assign opt_limb_s[i]  = {LIMB_W{1'b0}};
        assign opt_shift_s[i] = 32'd0;
      end
    end

    mult_limb_lane #(
      .WIDTH_A (WIDTH_A),
      .LIMB_W  (LIMB_W),
      .WIDTH_P (WIDTH_P)
    ) u_lane (
      .a     (a_r),
      .limb  (opt_limb_s[cnt_r]),
      .shift (opt_shift_s[cnt_r]),
      .pp    (pp_s[l])
    );

    assign chain_s[l+1] = chain_s[l] + pp_s[l];
  end

  // Control FSM, operand capture, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH_A{1'b0}};
      b_r       <= {B_PAD{1'b0}};
      acc_r     <= {WIDTH_P{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      p         <= {WIDTH_P{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= B_PAD'(b);
            acc_r   <= {WIDTH_P{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          acc_r <= chain_s[LANES];
          if (cnt_r == CNT_W'(ITER - 1)) begin
            cnt_r     <= {CNT_W{1'b0}};
            p         <= chain_s[LANES];
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_r     <= a;
              b_r     <= B_PAD'(b);
              acc_r   <= {WIDTH_P{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              busy    <= 1'b1;
              state_r <= BUSY;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_wide_iter.sv
// Self-checking bench: default instance scenarios plus three parameter sweeps against a*b.
module tb_mult_wide_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0, d_busy;
  logic [255:0] d_a = '0;
  logic [47:0]  d_b = '0;
  logic [303:0] d_p;

  // LANES=3
  logic s1_in_valid = 1'b0, s1_in_ready, s1_out_valid, s1_busy;
  logic [255:0] s1_a = '0;
  logic [47:0]  s1_b = '0;
  logic [303:0] s1_p;

  // WIDTH_B=40
  logic s2_in_valid = 1'b0, s2_in_ready, s2_out_valid, s2_busy;
  logic [255:0] s2_a = '0;
  logic [39:0]  s2_b = '0;
  logic [295:0] s2_p;

  // WIDTH_A=64, LIMB_W=24
  logic s3_in_valid = 1'b0, s3_in_ready, s3_out_valid, s3_busy;
  logic [63:0]  s3_a = '0;
  logic [47:0]  s3_b = '0;
  logic [111:0] s3_p;

  // Expected latencies from the limb arithmetic
  localparam int LAT_D  = (((48 + 15) / 16) + 0) / 1;
  localparam int LAT_S1 = (((48 + 15) / 16) + 2) / 3;
  localparam int LAT_S2 = (((40 + 15) / 16) + 0) / 1;
  localparam int LAT_S3 = (((48 + 23) / 24) + 0) / 1;

  mult_wide_iter u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready), .p(d_p), .busy(d_busy)
  );

  mult_wide_iter #(.LANES(3)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .out_valid(s1_out_valid), .out_ready(1'b1), .p(s1_p), .busy(s1_busy)
  );

  mult_wide_iter #(.WIDTH_B(40)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
    .a(s2_a), .b(s2_b), .out_valid(s2_out_valid), .out_ready(1'b1), .p(s2_p), .busy(s2_busy)
  );

  mult_wide_iter #(.WIDTH_A(64), .LIMB_W(24)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
    .a(s3_a), .b(s3_b), .out_valid(s3_out_valid), .out_ready(1'b1), .p(s3_p), .busy(s3_busy)
  );

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      default: for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    endcase
    return r;
  endfunction

  function automatic logic [303:0] model(input logic [255:0] av, input logic [47:0] bv);
    return 304'(av) * 304'(bv);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair to the default instance; report latency and busy cycles.
  task automatic d_issue(input logic [255:0] av, input logic [47:0] bv, output int lat, output int bc);
    int t;
    d_a = av;
    d_b = bv;
    d_in_valid = 1'b1;
    t = 0;
    while (!d_in_ready && t < 20) begin tick(); t++; end
    tick();
    d_in_valid = 1'b0;
    lat = 0;
    bc = 0;
    while (!d_out_valid && lat < 20) begin
      if (d_busy) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", d_out_valid); end
    checks++; if (d_p !== 304'd0) begin errors++; $display("FAIL reset_p got %h want 0", d_p); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", d_busy); end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", d_in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", d_in_ready); end
  endtask

  task automatic test_max();
    int lat, bc;
    logic [304:0] e;
    e = (305'd1 << 304) - (305'd1 << 256) - (305'd1 << 48) + 305'd1;
    d_out_ready = 1'b1;
    d_issue('1, '1, lat, bc);
    checks++; if (lat !== LAT_D) begin errors++; $display("FAIL max_latency got %0d want %0d", lat, LAT_D); end
    checks++; if (d_p !== e[303:0]) begin errors++; $display("FAIL max_product got %h want %h", d_p, e[303:0]); end
    tick();
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL max_drain got %b want 0", d_out_valid); end
  endtask

  task automatic test_hold();
    int lat, bc;
    logic [303:0] e;
    e = 304'h1234_0000_2468;
    d_out_ready = 1'b0;
    d_issue(256'h1234, 48'h0001_0000_0002, lat, bc);
    checks++; if (lat !== LAT_D) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat, LAT_D); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (d_out_valid !== 1'b1 || d_p !== e) begin errors++; $display("FAIL hold_stable cyc %0d got v=%b p=%h want v=1 p=%h", i, d_out_valid, d_p, e); end
      checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, d_in_ready); end
      tick();
    end
    d_out_ready = 1'b1;
    #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", d_in_ready); end
    tick();
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %b want 0", d_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] pa [3];
    logic [47:0]  pb [3];
    int n_in, n_out, last;
    logic go;
    pa[0] = 256'd3; pb[0] = 48'd5;
    pa[1] = 256'd7; pb[1] = 48'd11;
    pa[2] = 256'd1 << 255; pb[2] = 48'd2;
    n_in = 0; n_out = 0; last = 0;
    d_out_ready = 1'b1;
    d_a = pa[0]; d_b = pb[0]; d_in_valid = 1'b1;
    for (int c = 0; c < 40 && n_out < 3; c++) begin
      go = d_in_valid && d_in_ready;
      tick();
      if (go) begin
        n_in++;
        if (n_in < 3) begin d_a = pa[n_in]; d_b = pb[n_in]; end
        else d_in_valid = 1'b0;
      end
      if (d_out_valid) begin
        checks++; if (d_p !== model(pa[n_out], pb[n_out])) begin errors++; $display("FAIL b2b_product %0d got %h want %h", n_out, d_p, model(pa[n_out], pb[n_out])); end
        if (n_out > 0) begin
          checks++; if (c - last !== 4) begin errors++; $display("FAIL b2b_spacing %0d got %0d want 4", n_out, c - last); end
        end
        last = c;
        n_out++;
      end
    end
    checks++; if (n_out !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_out); end
    d_in_valid = 1'b0;
    n_out = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d_out_valid) n_out++;
    end
    checks++; if (n_out !== 0) begin errors++; $display("FAIL b2b_extra got %0d want 0", n_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, t, seen;
    logic [255:0] av;
    logic [47:0]  bv;
    d_out_ready = 1'b1;
    d_a = rnd256(); d_b = 48'hABCD_1234_5678; d_in_valid = 1'b1;
    t = 0;
    while (!d_in_ready && t < 20) begin tick(); t++; end
    tick();
    d_in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (d_out_valid !== 1'b0 || d_p !== 304'd0 || d_busy !== 1'b0) begin errors++; $display("FAIL midreset_state got v=%b p=%h busy=%b want 0/0/0", d_out_valid, d_p, d_busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", d_in_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (d_out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_dropped got %0d outputs want 0", seen); end
    av = rnd256();
    bv = 48'h0F0F_F0F0_1357;
    d_issue(av, bv, lat, bc);
    checks++; if (lat !== LAT_D || d_p !== model(av, bv)) begin errors++; $display("FAIL midreset_next got lat=%0d p=%h want lat=%0d p=%h", lat, d_p, LAT_D, model(av, bv)); end
    tick();
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [255:0] r;
    d_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r = rnd256() | 256'd1;
      if (k == 0) d_issue(256'd0, r[47:0], lat, bc);
      else d_issue(r, 48'd0, lat, bc);
      checks++; if (lat !== LAT_D) begin errors++; $display("FAIL zero_latency %0d got %0d want %0d", k, lat, LAT_D); end
      checks++; if (bc !== LAT_D) begin errors++; $display("FAIL zero_busy_cycles %0d got %0d want %0d", k, bc, LAT_D); end
      checks++; if (d_p !== 304'd0 || d_busy !== 1'b0) begin errors++; $display("FAIL zero_product %0d got p=%h busy=%b want 0/0", k, d_p, d_busy); end
      tick();
    end
  endtask

  task automatic test_random_default();
    int lat, bc;
    logic [255:0] av, r;
    logic [47:0]  bv;
    for (int i = 0; i < 200; i++) begin
      av = rnd256(); r = rnd256(); bv = r[47:0];
      d_out_ready = 1'b0;
      d_issue(av, bv, lat, bc);
      checks++; if (lat !== LAT_D || d_p !== model(av, bv)) begin errors++; $display("FAIL rand_default %0d got lat=%0d p=%h want lat=%0d p=%h", i, lat, d_p, LAT_D, model(av, bv)); end
      repeat ($urandom_range(0, 2)) tick();
      checks++; if (d_out_valid !== 1'b1 || d_p !== model(av, bv)) begin errors++; $display("FAIL rand_hold %0d got v=%b p=%h", i, d_out_valid, d_p); end
      d_out_ready = 1'b1;
      tick();
      d_out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep_lanes3();
    int lat, t;
    logic [255:0] av, r;
    logic [47:0]  bv;
    for (int i = 0; i < 1000; i++) begin
      av = rnd256(); r = rnd256(); bv = r[47:0];
      s1_a = av; s1_b = bv; s1_in_valid = 1'b1;
      t = 0;
      while (!s1_in_ready && t < 20) begin tick(); t++; end
      tick();
      s1_in_valid = 1'b0;
      lat = 0;
      while (!s1_out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== LAT_S1 || s1_p !== model(av, bv)) begin errors++; $display("FAIL sweep_lanes3 %0d got lat=%0d p=%h want lat=%0d p=%h", i, lat, s1_p, LAT_S1, model(av, bv)); end
    end
    tick();
  endtask

  task automatic test_sweep_b40();
    int lat, t;
    logic [255:0] av, r;
    logic [39:0]  bv;
    logic [295:0] e;
    for (int i = 0; i < 1000; i++) begin
      av = rnd256(); r = rnd256(); bv = r[39:0];
      e = 296'(av) * 296'(bv);
      s2_a = av; s2_b = bv; s2_in_valid = 1'b1;
      t = 0;
      while (!s2_in_ready && t < 20) begin tick(); t++; end
      tick();
      s2_in_valid = 1'b0;
      lat = 0;
      while (!s2_out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== LAT_S2 || s2_p !== e) begin errors++; $display("FAIL sweep_b40 %0d got lat=%0d p=%h want lat=%0d p=%h", i, lat, s2_p, LAT_S2, e); end
    end
    tick();
  endtask

  task automatic test_sweep_a64_l24();
    int lat, t;
    logic [255:0] r;
    logic [63:0]  av;
    logic [47:0]  bv;
    logic [111:0] e;
    for (int i = 0; i < 1000; i++) begin
      r = rnd256(); av = r[63:0];
      r = rnd256(); bv = r[47:0];
      e = 112'(av) * 112'(bv);
      s3_a = av; s3_b = bv; s3_in_valid = 1'b1;
      t = 0;
      while (!s3_in_ready && t < 20) begin tick(); t++; end
      tick();
      s3_in_valid = 1'b0;
      lat = 0;
      while (!s3_out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== LAT_S3 || s3_p !== e) begin errors++; $display("FAIL sweep_a64_l24 %0d got lat=%0d p=%h want lat=%0d p=%h", i, lat, s3_p, LAT_S3, e); end
    end
    tick();
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_max();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_random_default();
    test_sweep_lanes3();
    test_sweep_b40();
    test_sweep_a64_l24();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_wide_iter.md
Name: mult_wide_iter

Overview:
- Parametrised, handshaked successor to the fixed 256x48 registered multiplier.
- Computes an unsigned WIDTH_A x WIDTH_B product by splitting b into LIMB_W-bit limbs and processing LANES limbs per cycle.
- Accumulates the shifted partial products, trading latency for DSP count.
- Sits in the modular-multiplication datapath and drives downstream reduction through a valid/ready pair with backpressure.

Parameters:
- WIDTH_A, 256, width of operand a (unsigned).
- WIDTH_B, 48, width of operand b (unsigned).
- LIMB_W, 16, limb width of b per partial product (one DSP column).
- LANES, 1, limbs multiplied in parallel per cycle (1..NUM_LIMBS).
- Derived, not overridable:
  - NUM_LIMBS = ceil(WIDTH_B/LIMB_W)
  - ITER = ceil(NUM_LIMBS/LANES)
  - WIDTH_P = WIDTH_A+WIDTH_B

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH_A  multiplicand
- b  in  WIDTH_B  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  WIDTH_P  product a*b
- busy  out  1  high in BUSY state

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: all of the following take effect on the first edge with rst_n=0.
  - state=IDLE, out_valid=0, p=0, accumulator=0, iteration counter=0, busy=0.
  - in_ready=0 while rst_n=0.
  - A transaction in flight at reset is dropped; no out_valid is produced for it.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a; register b zero-extended to NUM_LIMBS*LIMB_W; clear acc and cnt; go to BUSY.
  - BUSY: each cycle acc <= acc + sum over l in 0..LANES-1 of a_r * limb[cnt*LANES+l] << ((cnt*LANES+l)*LIMB_W). Limb indices >= NUM_LIMBS contribute 0. cnt increments; when cnt==ITER-1, go to DONE on that edge. in_ready=0.
  - DONE: out_valid=1, p=acc.
    - p and out_valid hold stable while out_ready=0.
    - On out_ready=1: in_ready=1 combinationally (back-to-back). If in_valid is also 1, capture new operands and go to BUSY; otherwise go to IDLE with out_valid=0.
- Latency: operands accepted at edge N give out_valid=1 after edge N+ITER (defaults: ITER=3). Sustained throughput is one product per ITER+1 cycles; with out_ready tied high, back-to-back operation gives one per ITER+1 cycles.
- Arithmetic:
  - Unsigned only.
  - acc is WIDTH_P bits; the final sum cannot overflow.
  - Intermediate partial-product adds are truncated to WIDTH_P (the upper bits are provably zero).
- Boundary cases:
  - a=0 or b=0 still takes ITER cycles and gives p=0.
  - WIDTH_B not a multiple of LIMB_W: the top limb is zero-padded.
  - LANES>=NUM_LIMBS: ITER=1, so latency 1 plus handshake.
  - in_valid is ignored while in BUSY.
  - out_ready without out_valid has no effect.
- p is a register; it is never driven combinationally from the accumulator adder.

Decomposition:
- Shared package mult_pkg holds:
  - ceil-div function used for NUM_LIMBS and ITER;
  - FSM state enum (IDLE, BUSY, DONE).
- One sub-module, mult_limb_lane:
  - combinational WIDTH_A x LIMB_W product, shifted by a lane-dependent offset;
  - instantiated LANES times under generate;
  - the top level holds the FSM, counter, accumulator and handshake.

Test Plan:
- Defaults, a=2^256-1, b=2^48-1, out_ready=1 -> out_valid exactly 3 cycles after the accept edge; p = 2^304 - 2^256 - 2^48 + 1.
- Defaults, a=0x1234, b=0x0001_0000_0002, out_ready held 0 for 5 cycles after out_valid -> p=0x1234*0x100000002 stays stable; in_ready=0 until out_ready=1.
- Back-to-back: in_valid=1 continuously with pairs (3,5), (7,11), (2^255,2) and out_ready=1 -> products 15, 77, 2^256 in order, each 4 cycles apart, none lost or duplicated.
- Reset mid-op: rst_n=0 for 1 cycle during BUSY at cnt=1 -> no out_valid for that transaction; p=0; in_ready=1 on the first cycle after release; the next transaction is correct.
- Parameter sweeps (random 1000 vectors each against a golden a*b model):
  - LANES=3 -> ITER=1, out_valid 1 cycle after accept;
  - WIDTH_B=40 (padded top limb);
  - WIDTH_A=64, LIMB_W=24.
- b=0 and a=0 with defaults -> p=0 after 3 cycles; busy high for exactly 3 cycles.
